// File: rtl/wbs_ctrl_if.sv
// -----------------------------------------------------------------------------
// wbs_ctrl_if
//   Wishbone slave-side bus bundle for wbs_ctrl.
//   Ports (as seen by the slave modport):
//     wbs_stb_i, wbs_cyc_i, wbs_we_i  in   strobe / cycle / write enable
//     wbs_sel_i                       in   byte selects (full-word access only)
//     wbs_dat_i, wbs_adr_i            in   write data / byte address
//     wbs_ack_o                       out  one-cycle acknowledge pulse
//     wbs_dat_o                       out  read data, valid with ack
// -----------------------------------------------------------------------------
interface wbs_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wbs_ctrl.sv
// -----------------------------------------------------------------------------
// wbs_ctrl
//   Wishbone slave bridging the host bus to accelerator config/debug state.
//   adr[27:24] selects: 0 mode/debug regs, 1 query-patch SRAM, 2 leaf SRAM
//   banks, 3 best-match window (reads 0), 4 internal-node memory.
//   Memory words wider than 32 bits are accessed as two halves (adr[0]); a
//   lower-half write is parked in a holding register and the upper-half
//   write commits the full word to the SRAM.
//
//   Optional build macro: WBS_STRICT_DECODE_EN -- when defined, requests with
//   adr[31:28] != 4'h3 are never accepted (no ack, no side effects).
//
//   Ports:
//     wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//     wb                       Wishbone slave bundle (wbs_ctrl_if.slave)
//     wbs_mode, wbs_debug      control register outputs
//     wbs_qp_mem_*             query-patch SRAM port (csb0/web0 active low)
//     wbs_leaf_mem_*           leaf SRAM banks, per-bank csb0/web0 active low
//     wbs_node_mem_*           node memory port (web active high)
// -----------------------------------------------------------------------------
module wbs_ctrl #(
  parameter  int DATA_WIDTH  = 11,
  parameter  int LEAF_SIZE   = 8,
  parameter  int PATCH_SIZE  = 5,
  parameter  int ROW_SIZE    = 24,
  parameter  int COL_SIZE    = 17,
  parameter  int K           = 4,
  parameter  int NUM_LEAVES  = 64,
  localparam int NUM_QUERYS  = ROW_SIZE * COL_SIZE,
  localparam int QUERY_ADDRW = $clog2(NUM_QUERYS),
  localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES),
  localparam int PATCH_W     = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wbs_ctrl_if.slave              wb,
  output logic                   wbs_mode,
  output logic                   wbs_debug,
  output logic                   wbs_qp_mem_csb0,
  output logic                   wbs_qp_mem_web0,
  output logic [QUERY_ADDRW-1:0] wbs_qp_mem_addr0,
  output logic [PATCH_W-1:0]     wbs_qp_mem_wpatch0,
  input  logic [PATCH_W-1:0]     wbs_qp_mem_rpatch0,
  output logic [LEAF_SIZE-1:0]   wbs_leaf_mem_csb0,
  output logic [LEAF_SIZE-1:0]   wbs_leaf_mem_web0,
  output logic [LEAF_ADDRW-1:0]  wbs_leaf_mem_addr0,
  output logic [63:0]            wbs_leaf_mem_wleaf0,
  input  logic [63:0]            wbs_leaf_mem_rleaf0 [LEAF_SIZE],
  output logic                   wbs_node_mem_web,
  output logic [31:0]            wbs_node_mem_addr,
  output logic [31:0]            wbs_node_mem_wdata,
  input  logic [31:0]            wbs_node_mem_rdata
);

  localparam int BANK_W   = $clog2(LEAF_SIZE);
  localparam int unused_k = K;   // best-match count: no port use in this block

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;
  typedef enum logic [2:0] {T_REG, T_QUERY, T_LEAF, T_BEST, T_NODE, T_NONE} target_t;

  state_t            state, state_nxt;
  target_t           tgt_d, tgt_q;
  logic              in_window, accept, direct_d;
  logic              we_q, half_q;
  logic [BANK_W-1:0] bank_q;
  logic [31:0]       hold_q;
  logic [63:0]       rd_word;
  logic [31:0]       rd_half;
  logic              unused_bits;

  assign unused_bits = &{1'b0, wb.wbs_sel_i, wb.wbs_adr_i[31:28]};

`ifdef WBS_STRICT_DECODE_EN
  assign in_window = (wb.wbs_adr_i[31:28] == 4'h3);
`else
  assign in_window = 1'b1;
`endif

  assign accept = (state == S_IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i && in_window;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    tgt_d = T_NONE;
    case (wb.wbs_adr_i[27:24])
      4'h0:    tgt_d = T_REG;
      4'h1:    tgt_d = T_QUERY;
      4'h2:    tgt_d = T_LEAF;
      4'h3:    tgt_d = T_BEST;
      4'h4:    tgt_d = T_NODE;
      default: tgt_d = T_NONE;
    endcase
  end

  // Requests that never touch a memory port go straight to ACK; a lower-half
  // write only fills the holding register.
  assign direct_d = (tgt_d inside {T_REG, T_BEST, T_NONE}) ||
                    (wb.wbs_we_i && !wb.wbs_adr_i[0] && (tgt_d inside {T_QUERY, T_LEAF}));

  // State register
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = direct_d ? S_ACK : S_REQ;
      S_REQ:   state_nxt = we_q ? S_ACK : S_WAIT;
      S_WAIT:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: memory strobes are only active for the single REQ cycle
  always_comb begin
    wb.wbs_ack_o      = (state == S_ACK);
    wbs_qp_mem_csb0   = !((state == S_REQ) && (tgt_q == T_QUERY));
    wbs_qp_mem_web0   = !((state == S_REQ) && (tgt_q == T_QUERY) && we_q);
    wbs_node_mem_web  = (state == S_REQ) && (tgt_q == T_NODE) && we_q;
    wbs_leaf_mem_csb0 = '1;
    wbs_leaf_mem_web0 = '1;
    for (int b = 0; b < LEAF_SIZE; b++) begin
      if ((state == S_REQ) && (tgt_q == T_LEAF) && (bank_q == BANK_W'(b))) begin
        wbs_leaf_mem_csb0[b] = 1'b0;
        wbs_leaf_mem_web0[b] = !we_q;
      end
    end
  end

  // Read-data selection, used while the synchronous SRAM output is valid (WAIT)
  always_comb begin
    rd_word = '0;
    case (tgt_q)
      T_QUERY: rd_word = {{(64-PATCH_W){1'b0}}, wbs_qp_mem_rpatch0};
      T_LEAF:  rd_word = wbs_leaf_mem_rleaf0[bank_q];
      T_NODE:  rd_word = {32'b0, wbs_node_mem_rdata};
      default: rd_word = '0;
    endcase
    rd_half = (half_q && (tgt_q != T_NODE)) ? rd_word[63:32] : rd_word[31:0];
  end

  // Request capture; addresses and write data hold their last value when idle.
  // NOTE: these capture flops need no reset: every strobe they feed is qualified by the reset FSM state.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      tgt_q  <= tgt_d;
      we_q   <= wb.wbs_we_i;
      half_q <= wb.wbs_adr_i[0];
      bank_q <= wb.wbs_adr_i[1 +: BANK_W];
      if ((tgt_d == T_QUERY) && !direct_d) begin
        wbs_qp_mem_addr0   <= wb.wbs_adr_i[1 +: QUERY_ADDRW];
        wbs_qp_mem_wpatch0 <= {wb.wbs_dat_i[PATCH_W-33:0], hold_q};
      end
      if ((tgt_d == T_LEAF) && !direct_d) begin
        wbs_leaf_mem_addr0  <= wb.wbs_adr_i[4 +: LEAF_ADDRW];
        wbs_leaf_mem_wleaf0 <= {wb.wbs_dat_i, hold_q};
      end
      if (tgt_d == T_NODE) begin
        wbs_node_mem_addr  <= {8'b0, wb.wbs_adr_i[23:0]};
        wbs_node_mem_wdata <= wb.wbs_dat_i;
      end
    end
  end

  // Control registers, holding register and read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_dat_o <= '0;
      wbs_mode     <= 1'b0;
      wbs_debug    <= 1'b0;
      hold_q       <= '0;
    end else begin
      if (accept) begin
        case (tgt_d)
          T_REG: begin
            if (wb.wbs_we_i) begin
              if (wb.wbs_adr_i[0]) wbs_debug <= wb.wbs_dat_i[0];
              else                 wbs_mode  <= wb.wbs_dat_i[0];
            end else begin
              wb.wbs_dat_o <= {31'b0, wb.wbs_adr_i[0] ? wbs_debug : wbs_mode};
            end
          end
          T_QUERY, T_LEAF: if (wb.wbs_we_i && !wb.wbs_adr_i[0]) hold_q <= wb.wbs_dat_i;
          T_NODE: ;
          default: if (!wb.wbs_we_i) wb.wbs_dat_o <= '0;
        endcase
      end
      if (state == S_WAIT) wb.wbs_dat_o <= rd_half;
    end
  end

endmodule

// File: tb/tb_wbs_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wbs_ctrl
//   Self-checking bench for wbs_ctrl. A driver issues Wishbone transfers and
//   pushes the expected response into a scoreboard queue; a monitor pops and
//   compares on every ack. Expected data comes from a word-level reference
//   model of the register map; SRAM/node memories are behavioural models.
// -----------------------------------------------------------------------------
module tb_wbs_ctrl;

  localparam int PATCH_W = 55;
  localparam int QAW     = 9;
  localparam int LAW     = 6;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wbs_ctrl_if wb ();

  logic               mode, debug;
  logic               qp_csb, qp_web;
  logic [QAW-1:0]     qp_addr;
  logic [PATCH_W-1:0] qp_wpatch, qp_rpatch;
  logic [7:0]         leaf_csb, leaf_web;
  logic [LAW-1:0]     leaf_addr;
  logic [63:0]        leaf_wdata;
  logic [63:0]        leaf_rd [8];
  logic               node_web;
  logic [31:0]        node_addr, node_wdata, node_rd;

  wbs_ctrl dut (
    .wb_clk_i            (clk),
    .wb_rst_i            (rst),
    .wb                  (wb),
    .wbs_mode            (mode),
    .wbs_debug           (debug),
    .wbs_qp_mem_csb0     (qp_csb),
    .wbs_qp_mem_web0     (qp_web),
    .wbs_qp_mem_addr0    (qp_addr),
    .wbs_qp_mem_wpatch0  (qp_wpatch),
    .wbs_qp_mem_rpatch0  (qp_rpatch),
    .wbs_leaf_mem_csb0   (leaf_csb),
    .wbs_leaf_mem_web0   (leaf_web),
    .wbs_leaf_mem_addr0  (leaf_addr),
    .wbs_leaf_mem_wleaf0 (leaf_wdata),
    .wbs_leaf_mem_rleaf0 (leaf_rd),
    .wbs_node_mem_web    (node_web),
    .wbs_node_mem_addr   (node_addr),
    .wbs_node_mem_wdata  (node_wdata),
    .wbs_node_mem_rdata  (node_rd)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Deterministic initial memory contents, shared by the memory models and the reference
  function automatic logic [63:0] mix(input int unsigned a, input int unsigned b);
    int unsigned x;
    x = (a * 32'h9E37_79B1) ^ (b * 32'h85EB_CA6B) ^ 32'h1234_5678;
    return {x, (x * 32'hC2B2_AE35) + b};
  endfunction

  function automatic logic [PATCH_W-1:0] init_q(input int i);
    if (i == 1) return 55'h00_1010_DEAD_BEEF;
    return PATCH_W'(mix(1, i));
  endfunction

  function automatic logic [63:0] init_l(input int b, input int a);
    if (b == 7 && a == 0) return 64'h1100_1010_DEAD_BEEF;
    return mix(2, b * 64 + a);
  endfunction

  function automatic logic [31:0] init_n(input int i);
    return 32'(mix(3, i));
  endfunction

  // ---------------- memory models (synchronous, one-cycle read) ----------------
  logic [PATCH_W-1:0] qmem [512];
  logic [63:0]        lmem [8][64];
  logic [31:0]        nmem [256];

  initial begin
    for (int i = 0; i < 512; i++) qmem[i] <= init_q(i);
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 64; a++) lmem[b][a] <= init_l(b, a);
    for (int i = 0; i < 256; i++) nmem[i] <= init_n(i);
    forever begin
      @(posedge clk);
      if (!qp_csb) begin
        if (!qp_web) qmem[qp_addr] <= qp_wpatch;
        else         qp_rpatch     <= qmem[qp_addr];
      end
      for (int b = 0; b < 8; b++) begin
        if (!leaf_csb[b]) begin
          if (!leaf_web[b]) lmem[b][leaf_addr] <= leaf_wdata;
          else              leaf_rd[b]         <= lmem[b][leaf_addr];
        end
      end
      if (node_web) nmem[node_addr[7:0]] <= node_wdata;
      node_rd <= nmem[node_addr[7:0]];
    end
  end

  // ---------------- strobe activity counters ----------------
  int                 qp_rd_n = 0, qp_wr_n = 0, node_wr_n = 0;
  int                 leaf_sel_n [8] = '{default: 0};
  logic [QAW-1:0]     qp_addr_seen;
  logic [PATCH_W-1:0] qp_wpatch_seen;
  logic [31:0]        node_addr_seen, node_wdata_seen;

  always @(negedge clk) begin
    if (!qp_csb) begin
      qp_addr_seen = qp_addr;
      if (qp_web) qp_rd_n++;
      else begin
        qp_wr_n++;
        qp_wpatch_seen = qp_wpatch;
      end
    end
    for (int b = 0; b < 8; b++) if (!leaf_csb[b]) leaf_sel_n[b]++;
    if (node_web) begin
      node_wr_n++;
      node_addr_seen  = node_addr;
      node_wdata_seen = node_wdata;
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t sb [$];
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (wb.wbs_ack_o) begin
      exp_t e;
      check("ack_one_cycle", prev_ack, 1'b0);
      check("ack_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.is_rd) check("rd_data", wb.wbs_dat_o, e.data);
      end
    end
    prev_ack = wb.wbs_ack_o;
  end

  // ---------------- reference model ----------------
  logic [PATCH_W-1:0] q_ref [512];
  logic [63:0]        l_ref [8][64];
  logic [31:0]        n_ref [256];
  logic [31:0]        hold_ref  = '0;
  logic               mode_ref  = 1'b0;
  logic               debug_ref = 1'b0;

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    logic [63:0] w;
    case (adr[27:24])
      4'h0: return {31'b0, adr[0] ? debug_ref : mode_ref};
      4'h1: begin
        w = {9'b0, q_ref[adr[9:1]]};
        return adr[0] ? w[63:32] : w[31:0];
      end
      4'h2: begin
        w = l_ref[adr[3:1]][adr[9:4]];
        return adr[0] ? w[63:32] : w[31:0];
      end
      4'h4:    return n_ref[adr[7:0]];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] dat);
    case (adr[27:24])
      4'h0: if (adr[0]) debug_ref = dat[0]; else mode_ref = dat[0];
      4'h1: if (!adr[0]) hold_ref = dat; else q_ref[adr[9:1]] = {dat[22:0], hold_ref};
      4'h2: if (!adr[0]) hold_ref = dat; else l_ref[adr[3:1]][adr[9:4]] = {dat, hold_ref};
      4'h4: n_ref[adr[7:0]] = dat;
      default: ;
    endcase
  endtask

  // Cycles from request presentation to the ack sample: direct 2, memory write 3, memory read 4
  function automatic int exp_lat(input logic [31:0] adr, input logic we);
    case (adr[27:24])
      4'h1, 4'h2: return (we && !adr[0]) ? 2 : (we ? 3 : 4);
      4'h4:       return we ? 3 : 4;
      default:    return 2;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input bit drop, output int lat);
    bit got = 0;
    lat = 0;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = 4'($urandom);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if (drop && i == 2) begin
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
      end
      if (wb.wbs_ack_o) begin
        got = 1;
        lat = i;
      end
    end
    check("ack_seen", got, 1'b1);
    @(posedge clk);
    #1;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] adr, input logic [31:0] dat, input bit drop);
    exp_t e;
    int   lat;
    e.is_rd = 1'b0;
    e.data  = '0;
    model_write(adr, dat);
    sb.push_back(e);
    xfer(adr, dat, 1'b1, drop, lat);
    check("wr_latency", lat, exp_lat(adr, 1'b1));
  endtask

  task automatic do_rd(input logic [31:0] adr, input bit drop);
    exp_t e;
    int   lat;
    e.is_rd = 1'b1;
    e.data  = model_read(adr);
    sb.push_back(e);
    xfer(adr, 32'($urandom), 1'b0, drop, lat);
    check("rd_latency", lat, exp_lat(adr, 1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int qr0, qw0, nw0, others;
    int lb [8];
    logic [31:0] adr;

    for (int i = 0; i < 512; i++) q_ref[i] = init_q(i);
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 64; a++) l_ref[b][a] = init_l(b, a);
    for (int i = 0; i < 256; i++) n_ref[i] = init_n(i);

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = '0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb.wbs_ack_o, 1'b0);
    check("rst_dat_o", wb.wbs_dat_o, 32'h0);
    check("rst_mode_debug", {mode, debug}, 2'b00);
    check("rst_qp_strobes", {qp_csb, qp_web}, 2'b11);
    check("rst_leaf_strobes", {leaf_csb, leaf_web}, 16'hFFFF);
    check("rst_node_web", node_web, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Control registers
    do_wr(32'h3000_0001, 32'h1, 0);
    do_wr(32'h3000_0000, 32'h1, 0);
    check("debug_set", debug, 1'b1);
    check("mode_set", mode, 1'b1);
    do_rd(32'h3000_0000, 0);
    do_rd(32'h3000_0001, 0);

    // Query read, both halves
    qr0 = qp_rd_n; qw0 = qp_wr_n;
    do_rd(32'h3100_0002, 0);
    check("qp_rd_cycles", qp_rd_n - qr0, 1);
    check("qp_rd_no_write", qp_wr_n - qw0, 0);
    check("qp_rd_addr", qp_addr_seen, 9'd1);
    do_rd(32'h3100_0003, 0);

    // Query write: lower half parks, upper half commits
    qr0 = qp_rd_n; qw0 = qp_wr_n;
    do_wr(32'h3100_0004, 32'h0123_4567, 0);
    check("qp_lower_no_sram", (qp_wr_n - qw0) + (qp_rd_n - qr0), 0);
    do_wr(32'h3100_0005, 32'h000B_CDEF, 0);
    check("qp_wr_cycles", qp_wr_n - qw0, 1);
    check("qp_wr_addr", qp_addr_seen, 9'd2);
    check("qp_wr_patch", qp_wpatch_seen, 55'h0B_CDEF_0123_4567);
    do_rd(32'h3100_0004, 0);
    do_rd(32'h3100_0005, 0);

    // Leaf read: only bank 7 selected
    for (int b = 0; b < 8; b++) lb[b] = leaf_sel_n[b];
    do_rd(32'h3200_000E, 0);
    others = 0;
    for (int b = 0; b < 7; b++) others += leaf_sel_n[b] - lb[b];
    check("leaf_bank7_sel", leaf_sel_n[7] - lb[7], 1);
    check("leaf_other_banks", others, 0);
    do_rd(32'h3200_000F, 0);

    // Node write then read
    nw0 = node_wr_n;
    do_wr(32'h3400_0001, {10'b0, 11'd55, 11'd1}, 0);
    check("node_wr_cycles", node_wr_n - nw0, 1);
    check("node_wr_addr", node_addr_seen, 32'h1);
    check("node_wr_data", node_wdata_seen, 32'h0001_B801);
    do_rd(32'h3400_0001, 0);

    // BEST window and unmapped: reads 0, writes dropped
    do_wr(32'h3300_0010, 32'hFFFF_FFFF, 0);
    do_rd(32'h3300_0010, 0);
    do_wr(32'h3F00_0000, 32'h1234_5678, 0);
    do_rd(32'h3F00_0000, 0);
    check("mode_unchanged", {mode, debug}, {mode_ref, debug_ref});

    // cyc/stb dropped after accept: transfer still completes
    do_rd(32'h3100_0008, 1);
    do_rd(32'h3200_0021, 1);

    // Reset in the middle of a memory read: no ack, state cleared
    wb.wbs_adr_i = 32'h3100_0010;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode_ref  = 1'b0;
    debug_ref = 1'b0;
    hold_ref  = '0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_ack", wb.wbs_ack_o, 1'b0);
    check("abort_regs_cleared", {mode, debug}, 2'b00);
    check("abort_dat_o", wb.wbs_dat_o, 32'h0);

    // Holding register was cleared by reset
    do_wr(32'h3100_000B, 32'h0000_0007, 0);
    do_rd(32'h3100_000A, 0);
    do_rd(32'h3100_000B, 0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int  op;
      bit  drop;
      int  idx, bank, la, rgn;
      op   = $urandom_range(0, 9);
      drop = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 407);
      bank = $urandom_range(0, 7);
      la   = $urandom_range(0, 63);
      case (op)
        0: do_wr(32'h3000_0000 | 32'($urandom_range(0, 1)), $urandom, drop);
        1: do_rd(32'h3000_0000 | 32'($urandom_range(0, 1)), drop);
        2: do_wr(32'h3100_0000 | 32'(idx << 1), $urandom, drop);
        3: do_wr(32'h3100_0000 | 32'(idx << 1) | 32'h1, $urandom, drop);
        4: do_rd(32'h3100_0000 | 32'(idx << 1) | 32'($urandom_range(0, 1)), drop);
        5: do_wr(32'h3200_0000 | 32'(la << 4) | 32'(bank << 1), $urandom, drop);
        6: do_wr(32'h3200_0000 | 32'(la << 4) | 32'(bank << 1) | 32'h1, $urandom, drop);
        7: do_rd(32'h3200_0000 | 32'(la << 4) | 32'(bank << 1) | 32'($urandom_range(0, 1)), drop);
        8: begin
          adr = 32'h3400_0000 | 32'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 1) do_wr(adr, $urandom, drop);
          else                            do_rd(adr, drop);
        end
        default: begin
          rgn = $urandom_range(3, 15);
          if (rgn == 4) rgn = 3;
          adr = {4'h3, 4'(rgn), 24'($urandom)};
          if ($urandom_range(0, 1) == 1) do_wr(adr, $urandom, drop);
          else                            do_rd(adr, drop);
        end
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("final_regs", {mode, debug}, {mode_ref, debug_ref});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
